// File: rtl/mem_align_unit.sv
// Load/store alignment unit: splits boundary-crossing accesses into two bus
// transactions, positions store lanes and merges/extends load data.
module mem_align_unit #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter bit MISALIGNED_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [2:0]                req_mode,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      resp_valid,
  output logic                      resp_err,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH/8-1:0]   mem_be,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ACC0 = 3'd1;
  localparam logic [2:0] S_ACC1 = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            mode_q, mode_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [BYTES-1:0]      mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  logic                    idle;
  logic [ADDR_WIDTH-1:0]   src_addr;
  logic [2:0]              src_mode;
  logic [DATA_WIDTH-1:0]   src_wdata;
  logic [OFF-1:0]          off;
  logic [OFF+1:0]          size;
  logic [OFF+1:0]          end_pos;
  logic                    legal;
  logic                    split;
  logic [ADDR_WIDTH-1:0]   addr0;
  logic [ADDR_WIDTH-1:0]   addr1;
  logic [2*BYTES-1:0]      lane_mask;
  logic [2*BYTES-1:0]      be2;
  logic [DATA_WIDTH-1:0]   sized_wdata;
  logic [2*DATA_WIDTH-1:0] wide;
  logic [DATA_WIDTH-1:0]   rd_lo;
  logic [DATA_WIDTH-1:0]   rd_hi;
  logic [DATA_WIDTH-1:0]   merged;
  logic                    done;

  function automatic logic [DATA_WIDTH-1:0] extend(input logic [2:0] mode,
                                                   input logic [DATA_WIDTH-1:0] val);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    b = val[7:0];
    h = val[15:0];
    w = val[31:0];
    case (mode)
      3'b000:  extend = DATA_WIDTH'(b);
      3'b001:  extend = DATA_WIDTH'(h);
      3'b010:  extend = DATA_WIDTH'(w);
      3'b100:  extend = DATA_WIDTH'(val[7:0]);
      3'b101:  extend = DATA_WIDTH'(val[15:0]);
      default: extend = '0;
    endcase
  endfunction

  assign idle      = (state_q == S_IDLE);
  assign req_ready = idle;

  // Lane geometry comes from the live request in IDLE, else from the held one.
  always_comb begin
    src_addr    = idle ? req_addr  : addr_q;
    src_mode    = idle ? req_mode  : mode_q;
    src_wdata   = idle ? req_wdata : wdata_q;
    off         = src_addr[OFF-1:0];
    legal       = 1'b1;
    size        = '0;
    lane_mask   = '0;
    sized_wdata = '0;
    case (src_mode)
      3'b000, 3'b100: begin
        size        = (OFF+2)'(1);
        lane_mask   = (2*BYTES)'(4'b0001);
        sized_wdata = DATA_WIDTH'(src_wdata[7:0]);
      end
      3'b001, 3'b101: begin
        size        = (OFF+2)'(2);
        lane_mask   = (2*BYTES)'(4'b0011);
        sized_wdata = DATA_WIDTH'(src_wdata[15:0]);
      end
      3'b010: begin
        size        = (OFF+2)'(4);
        lane_mask   = (2*BYTES)'(4'b1111);
        sized_wdata = DATA_WIDTH'(src_wdata[31:0]);
      end
      default: legal = 1'b0;
    endcase
    end_pos = {2'b00, off} + size;
    split   = end_pos > (OFF+2)'(BYTES);
    addr0   = {src_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
    addr1   = addr0 + ADDR_WIDTH'(BYTES);
    be2     = lane_mask << off;
    wide    = {{DATA_WIDTH{1'b0}}, sized_wdata} << {off, 3'b000};
    rd_lo   = (state_q == S_ACC0) ? mem_rdata : data0_q;
    rd_hi   = (state_q == S_ACC1) ? mem_rdata : '0;
    merged  = DATA_WIDTH'({rd_hi, rd_lo} >> {off, 3'b000});
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    mode_d       = mode_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    data0_d      = data0_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    done         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          mode_d  = req_mode;
          write_d = req_write;
          wdata_d = req_wdata;
          if (!legal || (split && !MISALIGNED_EN)) begin
            state_d      = S_ERR;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = S_ACC0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_write;
            mem_addr_d  = addr0;
            mem_be_d    = be2[BYTES-1:0];
            mem_wdata_d = req_write ? wide[DATA_WIDTH-1:0] : '0;
          end
        end
      end
      S_ACC0: begin
        if (mem_ack) begin
          data0_d = mem_rdata;
          if (split) begin
            state_d     = S_ACC1;
            mem_addr_d  = addr1;
            mem_be_d    = be2[2*BYTES-1:BYTES];
            mem_wdata_d = write_q ? wide[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
          end else begin
            done = 1'b1;
          end
        end
      end
      S_ACC1:  done    = mem_ack;
      default: state_d = S_IDLE;
    endcase
    // Final acknowledge: release the bus and present the extended result.
    if (done) begin
      state_d      = S_RESP;
      resp_valid_d = 1'b1;
      resp_rdata_d = write_q ? '0 : extend(mode_q, merged);
      mem_req_d    = 1'b0;
      mem_we_d     = 1'b0;
      mem_be_d     = '0;
      mem_wdata_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    mode_q  <= mode_d;
    write_q <= write_d;
    wdata_q <= wdata_d;
    data0_q <= data0_d;
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_mem_align_unit.sv
// Bench for mem_align_unit: directed cases plus random loads/stores checked
// against a byte-addressed memory model.
module tb_mem_align_unit;
  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_mode;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        nm_req_valid, nm_req_ready, nm_resp_valid, nm_resp_err;
  logic [31:0] nm_resp_rdata, nm_mem_addr, nm_mem_wdata, nm_mem_rdata;
  logic        nm_mem_req, nm_mem_we, nm_mem_ack;
  logic [3:0]  nm_mem_be;

  typedef struct {
    bit [31:0] addr;
    bit [3:0]  be;
    bit [31:0] wdata;
    bit        we;
  } bus_t;

  bus_t      blog[$];
  bit [31:0] wmem [bit [31:0]];
  bit [7:0]  bmem [bit [31:0]];
  int        wait_cycles;
  int        ack_cnt;
  int        n_cmp, n_bad;
  logic      got_resp;
  int        lat;
  logic      o_err;
  logic [31:0] o_rdata;

  mem_align_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MISALIGNED_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata));

  mem_align_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MISALIGNED_EN(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .req_valid(nm_req_valid), .req_ready(nm_req_ready),
    .req_write(req_write), .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(nm_resp_valid), .resp_err(nm_resp_err), .resp_rdata(nm_resp_rdata),
    .mem_req(nm_mem_req), .mem_we(nm_mem_we), .mem_addr(nm_mem_addr), .mem_be(nm_mem_be),
    .mem_wdata(nm_mem_wdata), .mem_ack(nm_mem_ack), .mem_rdata(nm_mem_rdata));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic bit [31:0] rd_word(input bit [31:0] a);
    return wmem.exists(a) ? wmem[a] : 32'h0;
  endfunction

  function automatic bit [7:0] rd_byte(input bit [31:0] a);
    return bmem.exists(a) ? bmem[a] : 8'h0;
  endfunction

  function automatic int msize(input logic [2:0] md);
    case (md)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  task automatic poke_word(input bit [31:0] a, input bit [31:0] v);
    wmem[a] = v;
    for (int i = 0; i < 4; i++) bmem[a + i] = v[8*i +: 8];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %08h, expected %08h", tag, obs, exp);
    end
  endtask

  // Bus slave: acknowledges after wait_cycles idle cycles of mem_req.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    ack_cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_req && ack_cnt >= wait_cycles) begin
        bit [31:0] w;
        mem_ack = 1'b1;
        w = rd_word(mem_addr);
        if (mem_we) begin
          for (int i = 0; i < 4; i++) if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
          wmem[mem_addr] = w;
          mem_rdata = '0;
        end else begin
          mem_rdata = w;
        end
        blog.push_back('{addr: mem_addr, be: mem_be, wdata: mem_wdata, we: mem_we});
        ack_cnt = 0;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        ack_cnt = mem_req ? ack_cnt + 1 : 0;
      end
    end
  end

  task automatic do_access(input logic wr, input logic [2:0] md, input logic [31:0] ad,
                           input logic [31:0] wd, input int w);
    wait_cycles = w;
    blog.delete();
    @(negedge clk);
    req_write = wr; req_mode = md; req_addr = ad; req_wdata = wd; req_valid = 1'b1;
    check("req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    got_resp = 1'b0; lat = 0; o_err = 1'b0; o_rdata = '0;
    for (int k = 1; k <= 60 && !got_resp; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        got_resp = 1'b1; lat = k; o_err = resp_err; o_rdata = resp_rdata;
      end
    end
    check("resp_seen", {31'b0, got_resp}, 32'd1);
    @(negedge clk);
    check("pulse_end", {31'b0, resp_valid}, 32'd0);
  endtask

  // Expected behaviour derived from byte-level memory and the access rules.
  task automatic model_check(input logic wr, input logic [2:0] md, input logic [31:0] ad,
                             input logic [31:0] wd, input int w);
    int        sz, nacc;
    bit [31:0] a, word0, exp_val;
    bit [3:0]  exp_be;
    sz = msize(md);
    if (sz == 0) begin
      check("err_flag", {31'b0, o_err}, 32'd1);
      check("err_lat", lat, 32'd1);
      check("err_rdata", o_rdata, 32'd0);
      check("err_nbus", blog.size(), 32'd0);
    end else begin
      nacc = ((ad & 32'h3) + sz > 4) ? 2 : 1;
      word0 = ad & ~32'h3;
      check("lat", lat, 1 + nacc * (1 + w));
      check("err_flag", {31'b0, o_err}, 32'd0);
      check("nbus", blog.size(), nacc);
      for (int j = 0; j < nacc && j < blog.size(); j++) begin
        exp_be = '0;
        for (int i = 0; i < sz; i++) begin
          a = ad + i;
          if ((a & ~32'h3) == word0 + 4 * j) exp_be[a[1:0]] = 1'b1;
        end
        check("bus_addr", blog[j].addr, word0 + 4 * j);
        check("bus_be", {28'b0, blog[j].be}, {28'b0, exp_be});
        check("bus_we", {31'b0, blog[j].we}, {31'b0, wr});
      end
      if (wr) begin
        for (int i = 0; i < sz; i++) bmem[ad + i] = wd[8*i +: 8];
        check("st_rdata", o_rdata, 32'd0);
      end else begin
        exp_val = '0;
        for (int i = 0; i < sz; i++) exp_val |= 32'(rd_byte(ad + i)) << (8 * i);
        if (!md[2] && sz < 4 && exp_val[8*sz-1]) exp_val |= ~((32'h1 << (8 * sz)) - 1);
        check("ld_rdata", o_rdata, exp_val);
      end
    end
  endtask

  task automatic run(input logic wr, input logic [2:0] md, input logic [31:0] ad,
                     input logic [31:0] wd, input int w);
    do_access(wr, md, ad, wd, w);
    model_check(wr, md, ad, wd, w);
  endtask

  initial begin
    logic [2:0] mode_tab [10];
    logic       saw;
    n_cmp = 0; n_bad = 0; wait_cycles = 0;
    rst_n = 1'b0; req_valid = 1'b0; nm_req_valid = 1'b0; req_write = 1'b0;
    req_mode = 3'b000; req_addr = '0; req_wdata = '0;
    nm_mem_ack = 1'b0; nm_mem_rdata = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_be", {28'b0, mem_be}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);

    poke_word(32'h100, 32'h80FF1234);
    run(1'b0, 3'b000, 32'h103, 32'h0, 0);
    check("lb_rdata", o_rdata, 32'hFFFFFF80);
    if (blog.size() == 1) begin
      check("lb_addr", blog[0].addr, 32'h100);
      check("lb_be", {28'b0, blog[0].be}, 32'h8);
    end
    run(1'b0, 3'b100, 32'h103, 32'h0, 0);
    check("lbu_rdata", o_rdata, 32'h00000080);

    poke_word(32'h100, 32'h80011234);
    run(1'b0, 3'b001, 32'h102, 32'h0, 0);
    check("lh_rdata", o_rdata, 32'hFFFF8001);
    check("lh_lat", lat, 32'd2);
    run(1'b0, 3'b101, 32'h102, 32'h0, 0);
    check("lhu_rdata", o_rdata, 32'h00008001);

    poke_word(32'h0FC, 32'h44332211);
    poke_word(32'h100, 32'h88776655);
    run(1'b0, 3'b010, 32'h0FE, 32'h0, 0);
    check("lw_split_rdata", o_rdata, 32'h66554433);
    check("lw_split_lat", lat, 32'd3);
    if (blog.size() == 2) begin
      check("lw_split_a0", blog[0].addr, 32'h0FC);
      check("lw_split_a1", blog[1].addr, 32'h100);
    end

    run(1'b1, 3'b001, 32'h103, 32'h0000BEEF, 0);
    if (blog.size() == 2) begin
      check("sh_a0", blog[0].addr, 32'h100);
      check("sh_be0", {28'b0, blog[0].be}, 32'h8);
      check("sh_wd0", blog[0].wdata, 32'hEF000000);
      check("sh_a1", blog[1].addr, 32'h104);
      check("sh_be1", {28'b0, blog[1].be}, 32'h1);
      check("sh_wd1", blog[1].wdata, 32'h000000BE);
    end

    poke_word(32'hFFFFFFFC, 32'hA1B2C3D4);
    poke_word(32'h00000000, 32'h5E6F7A8B);
    run(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 2);
    check("wrap_lat", lat, 32'd7);
    check("wrap_rdata", o_rdata, 32'h7A8BA1B2);
    if (blog.size() == 2) check("wrap_a1", blog[1].addr, 32'h0);

    run(1'b0, 3'b011, 32'h100, 32'h0, 0);
    check("ill_err", {31'b0, o_err}, 32'd1);

    @(negedge clk);
    req_write = 1'b0; req_mode = 3'b010; req_addr = 32'h101; nm_req_valid = 1'b1;
    check("nm_ready", {31'b0, nm_req_ready}, 32'd1);
    @(posedge clk);
    #1 nm_req_valid = 1'b0;
    @(negedge clk);
    check("nm_resp_valid", {31'b0, nm_resp_valid}, 32'd1);
    check("nm_resp_err", {31'b0, nm_resp_err}, 32'd1);
    check("nm_resp_rdata", nm_resp_rdata, 32'd0);
    check("nm_mem_req", {31'b0, nm_mem_req}, 32'd0);
    check("nm_mem_bus", {nm_mem_addr[27:0], nm_mem_be}, 32'd0);
    check("nm_mem_wd", nm_mem_wdata | {31'b0, nm_mem_we}, 32'd0);

    // Reset while the second half of a split load is outstanding.
    wait_cycles = 3;
    blog.delete();
    @(negedge clk);
    req_write = 1'b0; req_mode = 3'b010; req_addr = 32'h0FE; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 0; k < 20 && blog.size() == 0; k++) @(negedge clk);
    check("abort_acc0_done", blog.size(), 32'd1);
    @(negedge clk);
    check("abort_in_acc1", {31'b0, mem_req}, 32'd1);
    check("abort_acc1_addr", mem_addr, 32'h100);
    #1 rst_n = 1'b0;
    #1;
    check("abort_req_drop", {31'b0, mem_req}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid) saw = 1'b1;
    end
    check("abort_no_resp", {31'b0, saw}, 32'd0);
    check("abort_ready", {31'b0, req_ready}, 32'd1);

    mode_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b001, 3'b010, 3'b011, 3'b110};
    for (int a = 32'h200; a < 32'h220; a += 4) poke_word(a, $urandom);
    for (int t = 0; t < 80; t++) begin
      logic        wr;
      logic [2:0]  md;
      logic [31:0] ad, wd;
      int          w;
      wr = 1'($urandom_range(0, 1));
      md = mode_tab[$urandom_range(0, 9)];
      ad = 32'h200 + $urandom_range(0, 27);
      wd = $urandom;
      w  = $urandom_range(0, 2);
      run(wr, md, ad, wd, w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_align_unit.md
# mem_align_unit

Parametrised load/store alignment unit between the core's memory stage and a data-memory/cache bus port. It accepts one byte, halfword or word access at a time over a valid/ready handshake. Accesses that cross a bus-word boundary are split into two bus transactions. The unit generates byte enables and shifted write data, then merges, extracts and sign- or zero-extends read data. Unlike the previous combinational read-extract path, it supports halfwords, misaligned accesses, store byte enables, wide buses and a multi-cycle memory acknowledge.

## Interface
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, bus/word width; power of two, ≥32; BYTES = DATA_WIDTH/8, OFF = log2(BYTES).
- MISALIGNED_EN, 1, 1 = split boundary-crossing accesses, 0 = reject them with resp_err.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  access request.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_mode  in  3  `DATA_ADDR_MODE_*`: B=000, H=001, W=010, BU=100, HU=101.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid; illegal mode or rejected misaligned access.
- resp_rdata  out  DATA_WIDTH  extended load result; 0 for stores and errors.
- mem_req  out  1  bus request, held until mem_ack.
- mem_we  out  1  bus write.
- mem_addr  out  ADDR_WIDTH  bus-word-aligned address (low OFF bits 0).
- mem_be  out  BYTES  byte enables.
- mem_wdata  out  DATA_WIDTH  lane-positioned write data.
- mem_ack  in  1  transaction complete; mem_rdata valid in the same cycle for reads.
- mem_rdata  in  DATA_WIDTH  read data.

## Operation
- Size: B/BU = 1, H/HU = 2, W = 4 bytes. Other modes are illegal. Stores ignore the U variants (BU→B, HU→H).
- off = req_addr[OFF-1:0]. split = off + size > BYTES.
- The request is registered on the req_valid && req_ready edge: addr, mode, write, wdata.
- Store lanes: wide = sized wdata << (8·off) over 2·DATA_WIDTH bits. be2 = ((1<<size)-1) << off over 2·BYTES bits.
  - Access 0 uses the low halves of wide and be2.
  - Access 1 uses the high halves.
- Load merge: {data1, data0} >> (8·off), then take the low size bytes. Sign-extend for B/H/W, zero-extend for BU/HU. W sign-extends only when DATA_WIDTH > 32.
- Loads always drive mem_be to the access byte mask; data is still taken from the lanes.
- Access 1 address: aligned addr + BYTES, modulo 2^ADDR_WIDTH, so it wraps to 0.
- FSM:
  - IDLE: req_ready=1. On accept: illegal mode, or split with MISALIGNED_EN=0 → ERR. Otherwise → ACC0.
  - ACC0: mem_req=1 at the aligned addr. On mem_ack, capture data0; go to ACC1 if split, else RESP.
  - ACC1: mem_req=1 at addr+BYTES. On mem_ack, capture data1 → RESP.
  - RESP: resp_valid=1, resp_err=0 → IDLE.
  - ERR: resp_valid=1, resp_err=1, no bus activity → IDLE.
- mem_* outputs are registered and decoded from the state. mem_wdata, mem_be and mem_we are stable while mem_req=1.
- Reset, including mid-transaction: state returns to IDLE immediately. mem_req, resp_valid and resp_err go to 0; resp_rdata, mem_addr, mem_be and mem_wdata go to 0; mem_we goes to 0. No response is issued for the aborted access. req_ready=1 once rst_n deasserts.

## Timing
- Accept at edge T. mem_req is high from T+1 until mem_ack.
- Zero-wait memory: unsplit access gives resp_valid at T+2; split access gives T+3; error gives T+1.
- Each mem_ack wait cycle adds one cycle.
- No new request is accepted while a response is pending. The next accept can occur on the edge after resp_valid.
- resp_valid is exactly one cycle. There is no backpressure on resp.

## Test plan
- LB at 0x103 with word 0x80FF1234 → resp_rdata 0xFFFFFF80. LBU at the same address → 0x00000080. mem_addr 0x100, mem_be 1000.
- LH at 0x102 with word 0x80011234 → 0xFFFF8001. LHU → 0x00008001. resp_valid at T+2 with mem_ack tied high.
- LW at 0x0FE with [0x0FC]=0x44332211 and [0x100]=0x88776655 → two accesses at 0x0FC then 0x100, resp_rdata 0x66554433, resp_valid at T+3.
- SH 0x0000BEEF at 0x103 → access 0: addr 0x100, be 1000, wdata 0xEF000000. Access 1: addr 0x104, be 0001, wdata 0x000000BE.
- Wrap and wait states: LW at 0xFFFFFFFE with mem_ack delayed 2 cycles per access → second access addr 0x00000000, resp_valid at T+7.
- Errors and reset:
  - mode 011 → no mem_req, resp_err=1 at T+1, rdata 0.
  - MISALIGNED_EN=0 with LW at 0x101 → same result.
  - rst_n pulsed low in ACC1 → mem_req drops asynchronously, no resp_valid, req_ready=1 after release.
